id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 119 +++++++++++
 tb/tb_id_ex_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and EX-stage operand forwarding.
// Operands are selected combinationally from the register and the MEM/WB results.
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [3:0]  id_ctl,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic        id_alusrc,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_dest,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        id_memwrite,
  input  logic        flush,
  output logic        stall_out,
  input  logic        mem_regwrite,
  input  logic [4:0]  mem_dest,
  input  logic [31:0] mem_result,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_dest,
  input  logic [31:0] wb_result,
  output logic [3:0]  alu_ctl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_dest,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_valid
);

  logic        r_valid;
  logic [3:0]  r_ctl;
  logic [31:0] r_rs_data;
  logic [31:0] r_rt_data;
  logic [31:0] r_imm;
  logic        r_alusrc;
  logic [4:0]  r_rs;
  logic [4:0]  r_rt;
  logic [4:0]  r_dest;
  logic        r_regwrite;
  logic        r_memread;
  logic        r_memwrite;

  logic        w_stall;
  logic [31:0] w_fwd_rs;
  logic [31:0] w_fwd_rt;

  // A load in EX whose result the ID instruction reads cannot be forwarded in time.
  // rt only matters when it feeds the ALU or is the store data.
  always_comb begin
    w_stall = id_valid & r_valid & r_memread & (r_dest != 5'd0) &
              ((r_dest == id_rs) | ((r_dest == id_rt) & (~id_alusrc | id_memwrite)));
  end

  assign stall_out = w_stall;

  // Reset, flush and stall all load a bubble; the stalled instruction is re-presented.
  always_ff @(posedge clk) begin
    if (reset || flush || w_stall) begin
      r_valid    <= 1'b0;
      r_ctl      <= 4'd0;
      r_rs_data  <= 32'd0;
      r_rt_data  <= 32'd0;
      r_imm      <= 32'd0;
      r_alusrc   <= 1'b0;
      r_rs       <= 5'd0;
      r_rt       <= 5'd0;
      r_dest     <= 5'd0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
    end else begin
      r_valid    <= id_valid;
      r_ctl      <= id_ctl;
      r_rs_data  <= id_rs_data;
      r_rt_data  <= id_rt_data;
      r_imm      <= id_imm;
      r_alusrc   <= id_alusrc;
      r_rs       <= id_rs;
      r_rt       <= id_rt;
      r_dest     <= id_dest;
      r_regwrite <= id_regwrite & id_valid;
      r_memread  <= id_memread & id_valid;
      r_memwrite <= id_memwrite & id_valid;
    end
  end

  // The younger MEM result wins over WB; register 0 is hardwired and never forwarded.
  always_comb begin
    w_fwd_rs = r_rs_data;
    if (mem_regwrite && (mem_dest != 5'd0) && (mem_dest == r_rs))
      w_fwd_rs = mem_result;
    else if (wb_regwrite && (wb_dest != 5'd0) && (wb_dest == r_rs))
      w_fwd_rs = wb_result;

    w_fwd_rt = r_rt_data;
    if (mem_regwrite && (mem_dest != 5'd0) && (mem_dest == r_rt))
      w_fwd_rt = mem_result;
    else if (wb_regwrite && (wb_dest != 5'd0) && (wb_dest == r_rt))
      w_fwd_rt = wb_result;
  end

  assign alu_a         = w_fwd_rs;
  assign alu_b         = r_alusrc ? r_imm : w_fwd_rt;
  assign ex_store_data = w_fwd_rt;
  assign alu_ctl       = r_ctl;
  assign ex_dest       = r_dest;
  assign ex_regwrite   = r_regwrite;
  assign ex_memread    = r_memread;
  assign ex_memwrite   = r_memwrite;
  assign ex_valid      = r_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a reference model pushes expected EX outputs
// into a scoreboard queue when stimulus is driven; they are popped after the clock edge.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [3:0]  id_ctl;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_alusrc;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic        id_regwrite, id_memread, id_memwrite;
  logic        flush;
  logic        stall_out;
  logic        mem_regwrite;
  logic [4:0]  mem_dest;
  logic [31:0] mem_result;
  logic        wb_regwrite;
  logic [4:0]  wb_dest;
  logic [31:0] wb_result;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [4:0]  ex_dest;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_valid;

  id_ex_stage dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_ctl(id_ctl), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_alusrc(id_alusrc), .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .flush(flush), .stall_out(stall_out),
    .mem_regwrite(mem_regwrite), .mem_dest(mem_dest), .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_dest(wb_dest), .wb_result(wb_result),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .ex_store_data(ex_store_data),
    .ex_dest(ex_dest), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_valid(ex_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [3:0]  ctl;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] imm;
    logic        alusrc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
  } idPkt;

  typedef struct packed {
    logic        memRw;
    logic [4:0]  memDest;
    logic [31:0] memRes;
    logic        wbRw;
    logic [4:0]  wbDest;
    logic [31:0] wbRes;
  } fwdPkt;

  typedef struct packed {
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [4:0]  dest;
    logic        valid;
    logic        rw;
    logic        mr;
    logic        mw;
  } expPkt;

  expPkt scoreboard[$];
  idPkt  modelReg;
  idPkt  bubble;
  fwdPkt noFwd;
  logic  lastStall;
  int    checks = 0;
  int    errors = 0;

  // Every comparison funnels through here so the counts stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic idPkt mkOp(input logic [3:0] ctl, input logic [4:0] rs, input logic [31:0] rsd,
                                input logic [4:0] rt, input logic [31:0] rtd, input logic [31:0] imm,
                                input logic alusrc, input logic [4:0] dest, input logic rw,
                                input logic mr, input logic mw);
    idPkt p;
    p.valid = 1'b1; p.ctl = ctl; p.rsData = rsd; p.rtData = rtd; p.imm = imm;
    p.alusrc = alusrc; p.rs = rs; p.rt = rt; p.dest = dest;
    p.regwrite = rw; p.memread = mr; p.memwrite = mw;
    return p;
  endfunction

  function automatic fwdPkt mkFwd(input logic mrw, input logic [4:0] md, input logic [31:0] mres,
                                  input logic wrw, input logic [4:0] wd, input logic [31:0] wres);
    fwdPkt f;
    f.memRw = mrw; f.memDest = md; f.memRes = mres;
    f.wbRw = wrw; f.wbDest = wd; f.wbRes = wres;
    return f;
  endfunction

  function automatic logic [31:0] fwdValue(input logic [4:0] r, input logic [31:0] regVal, input fwdPkt f);
    if (f.memRw && f.memDest != 5'd0 && f.memDest == r) return f.memRes;
    if (f.wbRw && f.wbDest != 5'd0 && f.wbDest == r) return f.wbRes;
    return regVal;
  endfunction

  // Drive one cycle of stimulus, predict stall and the resulting EX outputs, then
  // compare the scoreboard head against the DUT just after the clock edge.
  task automatic applyStimulus(input idPkt p, input fwdPkt f, input logic fl, input logic rst);
    logic  expStall;
    expPkt e;
    expPkt got;
    @(negedge clk);
    id_valid = p.valid; id_ctl = p.ctl; id_rs_data = p.rsData; id_rt_data = p.rtData;
    id_imm = p.imm; id_alusrc = p.alusrc; id_rs = p.rs; id_rt = p.rt; id_dest = p.dest;
    id_regwrite = p.regwrite; id_memread = p.memread; id_memwrite = p.memwrite;
    mem_regwrite = f.memRw; mem_dest = f.memDest; mem_result = f.memRes;
    wb_regwrite = f.wbRw; wb_dest = f.wbDest; wb_result = f.wbRes;
    flush = fl; reset = rst;
    #1;
    expStall = modelReg.valid && modelReg.memread && modelReg.dest != 5'd0 && p.valid &&
               (modelReg.dest == p.rs || (modelReg.dest == p.rt && (!p.alusrc || p.memwrite)));
    lastStall = stall_out;
    checkOutput("stall_out", 32'(stall_out), 32'(expStall));
    if (rst || fl || expStall) begin
      modelReg = bubble;
    end else begin
      modelReg = p;
      modelReg.regwrite = p.regwrite & p.valid;
      modelReg.memread  = p.memread & p.valid;
      modelReg.memwrite = p.memwrite & p.valid;
    end
    e.ctl   = modelReg.ctl;
    e.a     = fwdValue(modelReg.rs, modelReg.rsData, f);
    e.sd    = fwdValue(modelReg.rt, modelReg.rtData, f);
    e.b     = modelReg.alusrc ? modelReg.imm : e.sd;
    e.dest  = modelReg.dest;
    e.valid = modelReg.valid;
    e.rw    = modelReg.regwrite;
    e.mr    = modelReg.memread;
    e.mw    = modelReg.memwrite;
    scoreboard.push_back(e);
    @(posedge clk);
    #1;
    reset = 1'b0;
    flush = 1'b0;
    if (scoreboard.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      got = scoreboard.pop_front();
      checkOutput("alu_ctl", 32'(alu_ctl), 32'(got.ctl));
      checkOutput("alu_a", alu_a, got.a);
      checkOutput("alu_b", alu_b, got.b);
      checkOutput("ex_store_data", ex_store_data, got.sd);
      checkOutput("ex_dest", 32'(ex_dest), 32'(got.dest));
      checkOutput("ex_flags", {28'd0, ex_valid, ex_regwrite, ex_memread, ex_memwrite},
                  {28'd0, got.valid, got.rw, got.mr, got.mw});
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idPkt  p;
    fwdPkt f;
    bubble   = '0;
    modelReg = '0;
    noFwd    = '0;
    reset = 1'b1; flush = 1'b0; id_valid = 1'b0;

    // Reset state
    applyStimulus(bubble, noFwd, 1'b0, 1'b1);
    checkOutput("reset ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("reset stall_out", 32'(stall_out), 32'd0);

    // Plain pass-through of an ADD
    applyStimulus(mkOp(4'b0010, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0), noFwd, 1'b0, 1'b0);
    checkOutput("pass alu_ctl", 32'(alu_ctl), 32'h2);
    checkOutput("pass alu_a", alu_a, 32'd5);
    checkOutput("pass alu_b", alu_b, 32'd7);
    checkOutput("pass ex_valid", 32'(ex_valid), 32'd1);

    // MEM forwarding beats WB; WB used once MEM drops out
    applyStimulus(mkOp(4'b0010, 5'd8, 32'h99, 5'd2, 32'd1, 32'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0),
                  mkFwd(1'b1, 5'd8, 32'h11, 1'b1, 5'd8, 32'h22), 1'b0, 1'b0);
    checkOutput("fwd mem alu_a", alu_a, 32'h11);
    mem_regwrite = 1'b0;
    #1;
    checkOutput("fwd wb alu_a", alu_a, 32'h22);

    // Register 0 is never forwarded
    applyStimulus(mkOp(4'b0010, 5'd1, 32'd0, 5'd0, 32'h1234, 32'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0),
                  mkFwd(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0), 1'b0, 1'b0);
    checkOutput("r0 alu_b", alu_b, 32'h1234);

    // Load-use stall, bubble, then forwarded retry
    applyStimulus(mkOp(4'b0010, 5'd1, 32'd100, 5'd9, 32'd0, 32'd4, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0), noFwd, 1'b0, 1'b0);
    p = mkOp(4'b0010, 5'd9, 32'd0, 5'd2, 32'd6, 32'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
    applyStimulus(p, noFwd, 1'b0, 1'b0);
    checkOutput("loaduse stall", 32'(lastStall), 32'd1);
    checkOutput("loaduse bubble valid", 32'(ex_valid), 32'd0);
    checkOutput("loaduse bubble regwrite", 32'(ex_regwrite), 32'd0);
    applyStimulus(p, mkFwd(1'b1, 5'd9, 32'hABC, 1'b0, 5'd0, 32'd0), 1'b0, 1'b0);
    checkOutput("loaduse retry stall", 32'(lastStall), 32'd0);
    checkOutput("loaduse retry alu_a", alu_a, 32'hABC);

    // Immediate operand: rt match against the load is harmless
    applyStimulus(mkOp(4'b0010, 5'd1, 32'd100, 5'd9, 32'd0, 32'd4, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0), noFwd, 1'b0, 1'b0);
    applyStimulus(mkOp(4'b0010, 5'd4, 32'd1, 5'd9, 32'd3, 32'hFFFF_FFFC, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0), noFwd, 1'b0, 1'b0);
    checkOutput("imm stall", 32'(lastStall), 32'd0);
    checkOutput("imm alu_b", alu_b, 32'hFFFF_FFFC);
    checkOutput("imm store_data", ex_store_data, 32'd3);

    // Store whose data register is the load destination must stall
    applyStimulus(mkOp(4'b0010, 5'd1, 32'd100, 5'd9, 32'd0, 32'd4, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0), noFwd, 1'b0, 1'b0);
    applyStimulus(mkOp(4'b0010, 5'd4, 32'd1, 5'd9, 32'd3, 32'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1), noFwd, 1'b0, 1'b0);
    checkOutput("store stall", 32'(lastStall), 32'd1);

    // Flush during a stall, then reset during a stall
    applyStimulus(mkOp(4'b0010, 5'd1, 32'd100, 5'd9, 32'd0, 32'd4, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0), noFwd, 1'b0, 1'b0);
    applyStimulus(p, noFwd, 1'b1, 1'b0);
    checkOutput("flush stall", 32'(lastStall), 32'd1);
    checkOutput("flush ex_valid", 32'(ex_valid), 32'd0);
    applyStimulus(mkOp(4'b0010, 5'd1, 32'd100, 5'd9, 32'd0, 32'd4, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0), noFwd, 1'b0, 1'b0);
    applyStimulus(p, noFwd, 1'b0, 1'b1);
    checkOutput("reset stall before", 32'(lastStall), 32'd1);
    checkOutput("reset stall after", 32'(stall_out), 32'd0);
    checkOutput("reset alu_a", alu_a, 32'd0);
    checkOutput("reset ex_dest", 32'(ex_dest), 32'd0);

    // Random traffic over a few registers to exercise hazards and forwarding together
    for (int i = 0; i < 60; i++) begin
      p.valid    = ($urandom_range(0, 3) != 0);
      p.ctl      = 4'($urandom_range(0, 15));
      p.rsData   = $urandom;
      p.rtData   = $urandom;
      p.imm      = $urandom;
      p.alusrc   = 1'($urandom_range(0, 1));
      p.rs       = 5'($urandom_range(0, 3));
      p.rt       = 5'($urandom_range(0, 3));
      p.dest     = 5'($urandom_range(0, 3));
      p.regwrite = 1'($urandom_range(0, 1));
      p.memread  = ($urandom_range(0, 2) == 0);
      p.memwrite = ($urandom_range(0, 3) == 0);
      f = mkFwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
      applyStimulus(p, f, ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
    end

    checkOutput("scoreboard drained", 32'(scoreboard.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
